// File: rtl/arb_4ch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arb_4ch_ctrl
// Description : Four-requester arbiter with bounded grant hold, one-cycle gap
//               between grants and timeout pulse on hold expiry. The winner
//               policy is fixed priority (req[3] highest) by default;
//               defining ARB_ROUND_ROBIN_EN selects round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_4ch_ctrl #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] c_last_cnt = 8'(MAX_HOLD - 1);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_grant, w_grant_nxt;
    logic [1:0] r_grant_id, w_grant_id_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_timeout, w_timeout_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [1:0] w_winner;
    logic       w_expire;
    logic       w_lost;
    logic       w_exit;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] r_last_id, w_last_id_nxt;
    logic       w_found;

    // Search begins one past the previous winner; offset 4 wraps back to it.
    always_comb begin
        w_winner = 2'd0;
        w_found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && req[r_last_id + 2'(k)]) begin
                w_winner = r_last_id + 2'(k);
                w_found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        if (req[3])      w_winner = 2'd3;
        else if (req[2]) w_winner = 2'd2;
        else if (req[1]) w_winner = 2'd1;
        else             w_winner = 2'd0;
    end
`endif

    assign w_expire = (r_cnt == c_last_cnt);
    assign w_lost   = ~req[r_grant_id];
    assign w_exit   = done | w_lost | w_expire;

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_busy_nxt     = r_busy;
        w_timeout_nxt  = 1'b0;
        w_cnt_nxt      = r_cnt;
`ifdef ARB_ROUND_ROBIN_EN
        w_last_id_nxt  = r_last_id;
`endif
        case (r_state)
            S_IDLE: begin
                if (req != 4'b0000) begin
                    w_state_nxt    = S_HOLD;
                    w_grant_nxt    = 4'b0001 << w_winner;
                    w_grant_id_nxt = w_winner;
                    w_busy_nxt     = 1'b1;
                    w_cnt_nxt      = 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
                    w_last_id_nxt  = w_winner;
`endif
                end
            end
            S_HOLD: begin
                if (w_exit) begin
                    // Timeout only when expiry is the sole reason to leave.
                    w_state_nxt   = S_GAP;
                    w_grant_nxt   = 4'b0000;
                    w_busy_nxt    = 1'b0;
                    w_timeout_nxt = w_expire & ~done & ~w_lost;
                    w_cnt_nxt     = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= 4'b0000;
            r_grant_id <= 2'b00;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt      <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_id  <= 2'b11;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_busy     <= w_busy_nxt;
            r_timeout  <= w_timeout_nxt;
            r_cnt      <= w_cnt_nxt;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_id  <= w_last_id_nxt;
`endif
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_arb_4ch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_4ch_ctrl
// Description : Self-checking bench for arb_4ch_ctrl: behavioural reference
//               model feeding a scoreboard queue, plus directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_4ch_ctrl;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int         m_state;
    int         m_cnt;
    logic [3:0] m_grant;
    logic [1:0] m_id;
    logic       m_busy;
    logic       m_to;
    logic [1:0] m_last;

    logic [7:0] sb[$];
    logic [1:0] seen[$];
    logic [3:0] prev_grant;
    int         n_to;

    arb_4ch_ctrl #(.MAX_HOLD(MAX_HOLD)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] pick(input logic [3:0] r);
        logic [1:0] i;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 4; k++) begin
            i = 2'((int'(m_last) + k) % 4);
            if (r[i]) return i;
        end
`else
        for (int k = 3; k >= 0; k--) begin
            i = 2'(k);
            if (r[i]) return i;
        end
`endif
        return 2'd0;
    endfunction

    task automatic model(input logic [3:0] r, input logic d, input logic rs);
        logic [1:0] w;
        if (rs) begin
            m_state = 0; m_cnt = 0; m_grant = 4'b0000; m_id = 2'b00;
            m_busy = 1'b0; m_to = 1'b0; m_last = 2'b11;
        end else begin
            m_to = 1'b0;
            case (m_state)
                0: if (r != 4'b0000) begin
                    w = pick(r);
                    m_grant = 4'b0001 << w;
                    m_id = w; m_busy = 1'b1; m_cnt = 0; m_last = w; m_state = 1;
                end
                1: if (d || !r[m_id] || m_cnt == MAX_HOLD - 1) begin
                    m_to = !d && r[m_id];
                    m_grant = 4'b0000; m_busy = 1'b0; m_state = 2;
                end else begin
                    m_cnt++;
                end
                default: m_state = 0;
            endcase
        end
    endtask

    // One clock: drive, push expectation, clock, pop and compare.
    task automatic step(input string tag, input logic [3:0] r, input logic d, input logic rs);
        logic [7:0] exp;
        logic [7:0] got;
        req = r; done = d; rst = rs;
        model(r, d, rs);
        sb.push_back({m_to, m_busy, (m_busy ? m_id : 2'b00), m_grant});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        got = {timeout, busy, (busy ? grant_id : 2'b00), grant};
        check_eq(tag, 32'(got), 32'(exp));
        if (timeout) n_to++;
        if (grant != 4'b0000 && prev_grant == 4'b0000) seen.push_back(grant_id);
        prev_grant = grant;
    endtask

    task automatic do_reset();
        step("rst", 4'b0000, 1'b0, 1'b1);
        step("rst", 4'b0000, 1'b0, 1'b1);
        seen.delete();
        n_to = 0;
    endtask

    logic [1:0] exp_seq[$];
    logic [3:0] exp_g;
    logic [3:0] rr;
    logic       rd;
    logic       rrs;

    initial begin
        req = 4'b0000; done = 1'b0; rst = 1'b1; prev_grant = 4'b0000; n_to = 0;
        model(4'b0000, 1'b0, 1'b1);

        do_reset();
        check_eq("reset_state", 32'({timeout, busy, grant_id, grant}), 32'd0);

        // single requester, done on 3rd hold cycle
        step("r030", 4'b0001, 1'b0, 1'b0);
        check_eq("r030_grant", 32'(grant), 32'h1);
        check_eq("r030_busy", 32'(busy), 32'h1);
        step("r030", 4'b0001, 1'b0, 1'b0);
        step("r030", 4'b0001, 1'b0, 1'b0);
        step("r030", 4'b0001, 1'b1, 1'b0);
        check_eq("r030_release", 32'({timeout, busy, grant}), 32'h0);

        // two requesters, done pulse each grant
        do_reset();
        for (int g = 0; g < 4; g++) begin
            step("r031", 4'b0101, 1'b0, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
            exp_g = (g % 2 == 0) ? 4'b0001 : 4'b0100;
`else
            exp_g = 4'b0100;
`endif
            check_eq("r031_grant", 32'(grant), 32'(exp_g));
            step("r031", 4'b0101, 1'b1, 1'b0);
            step("r031", 4'b0101, 1'b0, 1'b0);
        end

        // all requesting, no done: every grant times out
        do_reset();
        for (int c = 0; c < 50; c++) step("r032", 4'b1111, 1'b0, 1'b0);
        check_eq("r032_timeouts", 32'(n_to), 32'd5);
        check_eq("r032_grants", 32'(seen.size()), 32'd5);
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
        exp_seq = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
        for (int g = 0; g < 5 && g < seen.size(); g++)
            check_eq("r032_order", 32'(seen[g]), 32'(exp_seq[g]));

        // owner drops its request
        do_reset();
        step("r033", 4'b0100, 1'b0, 1'b0);
        check_eq("r033_grant", 32'(grant), 32'h4);
        step("r033", 4'b0100, 1'b0, 1'b0);
        step("r033", 4'b0100, 1'b0, 1'b0);
        step("r033", 4'b0001, 1'b0, 1'b0);
        check_eq("r033_drop", 32'({timeout, busy, grant}), 32'h0);
        step("r033", 4'b0001, 1'b0, 1'b0);
        check_eq("r033_gap", 32'(grant), 32'h0);
        step("r033", 4'b0001, 1'b0, 1'b0);
        check_eq("r033_next", 32'(grant), 32'h1);

        // reset in the middle of a hold
        do_reset();
        step("r034", 4'b1000, 1'b0, 1'b0);
        step("r034", 4'b1000, 1'b0, 1'b0);
        step("r034", 4'b1000, 1'b1, 1'b1);
        check_eq("r034_rst", 32'({busy, grant}), 32'h0);
        step("r034", 4'b1000, 1'b0, 1'b0);
        check_eq("r034_regrant", 32'(grant), 32'h8);

        // done coincides with expiry
        do_reset();
        step("r035", 4'b0010, 1'b0, 1'b0);
        for (int c = 0; c < MAX_HOLD - 1; c++) step("r035", 4'b0010, 1'b0, 1'b0);
        check_eq("r035_still", 32'(grant), 32'h2);
        step("r035", 4'b0010, 1'b1, 1'b0);
        check_eq("r035_exit", 32'({timeout, busy, grant}), 32'h0);

        // random traffic
        do_reset();
        rr = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 11) == 0) rr = 4'($urandom_range(0, 15));
            rd  = ($urandom_range(0, 7) == 0);
            rrs = ($urandom_range(0, 79) == 0);
            step("rand", rr, rd, rrs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
